// File: rtl/branch_unit.sv
// Branch resolution against the committed {N,V,Z} flag register, with registered PC
// redirect, multi-cycle IF/ID flush and saturating branch statistics.
module branch_unit #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic [3:0]       ex_aluop,
   input  logic [2:0]       alu_flags,
   input  logic             br_valid,
   input  logic [2:0]       br_ccc,
   input  logic [15:0]      br_target,
   output logic [2:0]       flag_reg,
   output logic             redirect,
   output logic [15:0]      redirect_pc,
   output logic             flush,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t     state, state_nx;
   logic [2:0] fcnt, fcnt_nx;
   logic       cond_met, eval, taken, flag_we;
   logic       fz, fv, fn;

   assign fz = flag_reg[0];
   assign fv = flag_reg[1];
   assign fn = flag_reg[2];

   // Conditions use the flags committed before this cycle's update.
   always_comb begin
      cond_met = 1'b0;
      case (br_ccc)
         3'b000: cond_met = ~fz;
         3'b001: cond_met = fz;
         3'b010: cond_met = ~fz & ~fn;
         3'b011: cond_met = fn;
         3'b100: cond_met = fz | ~fn;
         3'b101: cond_met = fz | fn;
         3'b110: cond_met = fv;
         3'b111: cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

   assign eval    = br_valid & ex_valid & ~stall & (state == IDLE);
   assign taken   = eval & cond_met;
   assign flag_we = ex_valid & ~stall & (ex_aluop <= 4'd7) & (state == IDLE);
   assign flush   = (state == FLUSH);

   always_comb begin
      state_nx = state;
      fcnt_nx  = fcnt;
      case (state)
         IDLE: if (taken) begin
            state_nx = FLUSH;
            fcnt_nx  = 3'(FLUSH_CYCLES);
         end
         FLUSH: if (!stall) begin
            if (fcnt == 3'd1) state_nx = IDLE;
            fcnt_nx = fcnt - 3'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         fcnt        <= 3'd0;
         flag_reg    <= 3'b000;
         redirect    <= 1'b0;
         redirect_pc <= 16'h0000;
         br_count    <= '0;
         taken_count <= '0;
      end else begin
         state    <= state_nx;
         fcnt     <= fcnt_nx;
         // Only a taken branch can raise this, so it self-clears after one cycle.
         redirect <= taken;
         if (taken)   redirect_pc <= br_target;
         if (flag_we) flag_reg    <= alu_flags;
         if (eval && br_count != '1)
            br_count <= br_count + {{(CNT_W-1){1'b0}}, 1'b1};
         if (taken && taken_count != '1)
            taken_count <= taken_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
